// File: rtl/vga_pkg.sv
// Default 800x600@60 raster constants and a window-compare helper.
package vga_pkg;

  localparam int CNT_W = 11;

  localparam int H_VISIBLE = 800;
  localparam int H_FP = 40;
  localparam int H_SYNC = 128;
  localparam int H_BP = 88;

  localparam int V_VISIBLE = 600;
  localparam int V_FP = 1;
  localparam int V_SYNC = 4;
  localparam int V_BP = 23;

  localparam int H_TOTAL =
    H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL =
    V_VISIBLE + V_FP + V_SYNC + V_BP;

  function automatic logic in_win(
    input logic [31:0] x,
    input logic [31:0] lo,
    input logic [31:0] hi
  );
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle; frame_cnt exists only with VGA_FRAME_CNT_EN.
interface vga_timing_if #(
  parameter int CNT_W = vga_pkg::CNT_W
);

  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic hsync;
  logic vsync;
  logic hblnk;
  logic vblnk;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt;

  modport master (
    output hcount, vcount,
    output hsync, vsync,
    output hblnk, vblnk,
    output frame_cnt
  );

  modport slave (
    input hcount, vcount,
    input hsync, vsync,
    input hblnk, vblnk,
    input frame_cnt
  );
`else
  modport master (
    output hcount, vcount,
    output hsync, vsync,
    output hblnk, vblnk
  );

  modport slave (
    input hcount, vcount,
    input hsync, vsync,
    input hblnk, vblnk
  );
`endif

endinterface

// File: rtl/vga_timing_wrap_counter.sv
// Modulo counter with enable; wrap_o pulses on the enabled terminal count.
module wrap_counter #(
  parameter int W = 11,
  parameter int MOD = 1056
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_d_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (wrap_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign cnt_d_o = cnt_d;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator; define VGA_FRAME_CNT_EN to add frame_cnt.
module vga_timing #(
  parameter int CNT_W = vga_pkg::CNT_W,
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FP = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP = vga_pkg::H_BP,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FP = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP = vga_pkg::V_BP
) (
  input logic          clk,
  input logic          rst,
  vga_timing_if.master vga
);
  import vga_pkg::*;

  localparam int H_TOTAL =
    H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL =
    V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam int HS_LO = H_VISIBLE + H_FP;
  localparam int HS_HI = HS_LO + H_SYNC - 1;
  localparam int VS_LO = V_VISIBLE + V_FP;
  localparam int VS_HI = VS_LO + V_SYNC - 1;

  if (H_TOTAL > (2 ** CNT_W)) begin : g_h_chk
    $error("H_TOTAL-1 does not fit in CNT_W");
  end
  if (V_TOTAL > (2 ** CNT_W)) begin : g_v_chk
    $error("V_TOTAL-1 does not fit in CNT_W");
  end

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] h_d;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] v_d;
  logic h_wrap;
`ifdef VGA_FRAME_CNT_EN
  logic v_wrap;
`else
  logic v_wrap_unused;
`endif

  wrap_counter #(
    .W   (CNT_W),
    .MOD (H_TOTAL)
  ) u_hcnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (1'b1),
    .cnt_o   (h_cnt),
    .cnt_d_o (h_d),
    .wrap_o  (h_wrap)
  );

  wrap_counter #(
    .W   (CNT_W),
    .MOD (V_TOTAL)
  ) u_vcnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (h_wrap),
    .cnt_o   (v_cnt),
    .cnt_d_o (v_d),
`ifdef VGA_FRAME_CNT_EN
    .wrap_o  (v_wrap)
`else
    .wrap_o  (v_wrap_unused)
`endif
  );

  // Flags decode next counts so they line up with the registered counts.
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic hblnk_q, hblnk_d;
  logic vblnk_q, vblnk_d;

  always_comb begin
    hblnk_d = 32'(h_d) >= 32'(H_VISIBLE);
    vblnk_d = 32'(v_d) >= 32'(V_VISIBLE);
    hsync_d = in_win(32'(h_d), HS_LO, HS_HI);
    vsync_d = in_win(32'(v_d), VS_LO, VS_HI);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      hblnk_q <= 1'b0;
      vblnk_q <= 1'b0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      hblnk_q <= hblnk_d;
      vblnk_q <= vblnk_d;
    end
  end

  assign vga.hcount = h_cnt;
  assign vga.vcount = v_cnt;
  assign vga.hsync = hsync_q;
  assign vga.vsync = vsync_q;
  assign vga.hblnk = hblnk_q;
  assign vga.vblnk = vblnk_q;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_q;
  logic [15:0] frame_d;

  assign frame_d = v_wrap ? frame_q + 16'd1 : frame_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
    end else begin
      frame_q <= frame_d;
    end
  end

  assign vga.frame_cnt = frame_q;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench: full-size and scaled-down rasters against an arithmetic model.
module tb_vga_timing;

  logic clk;
  logic rst;

  int checks = 0;
  int failures = 0;
  int n = 0;

  vga_timing_if #(.CNT_W(11)) if_full ();
  vga_timing_if #(.CNT_W(11)) if_small ();

  vga_timing dut_full (
    .clk (clk),
    .rst (rst),
    .vga (if_full)
  );

  vga_timing #(
    .CNT_W     (11),
    .H_VISIBLE (16),
    .H_FP      (4),
    .H_SYNC    (8),
    .H_BP      (4),
    .V_VISIBLE (12),
    .V_FP      (1),
    .V_SYNC    (2),
    .V_BP      (3)
  ) dut_small (
    .clk (clk),
    .rst (rst),
    .vga (if_small)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int h;
    int v;
    int hs;
    int vs;
    int hb;
    int vb;
    int fc;
  } ras_t;

  // Position after n edges since reset, from the raster rules alone.
  function automatic ras_t model(
    input int cyc,
    input int hv, input int hfp, input int hsw, input int hbp,
    input int vv, input int vfp, input int vsw, input int vbp
  );
    ras_t r;
    int ht, vt, f;
    ht = hv + hfp + hsw + hbp;
    vt = vv + vfp + vsw + vbp;
    f = cyc % (ht * vt);
    r.h = f % ht;
    r.v = f / ht;
    r.hb = (r.h >= hv) ? 1 : 0;
    r.vb = (r.v >= vv) ? 1 : 0;
    r.hs = (r.h >= hv + hfp && r.h < hv + hfp + hsw) ? 1 : 0;
    r.vs = (r.v >= vv + vfp && r.v < vv + vfp + vsw) ? 1 : 0;
    r.fc = (cyc / (ht * vt)) % 65536;
    return r;
  endfunction

  task automatic chk(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s n=%0d got=%0d exp=%0d", tag, n, got, exp);
    end
  endtask

  task automatic check_all();
    ras_t ef, es;
    ef = model(n, 800, 40, 128, 88, 600, 1, 4, 23);
    es = model(n, 16, 4, 8, 4, 12, 1, 2, 3);
    chk("full_hcount", 32'(if_full.hcount), ef.h);
    chk("full_vcount", 32'(if_full.vcount), ef.v);
    chk("full_hsync", 32'(if_full.hsync), ef.hs);
    chk("full_vsync", 32'(if_full.vsync), ef.vs);
    chk("full_hblnk", 32'(if_full.hblnk), ef.hb);
    chk("full_vblnk", 32'(if_full.vblnk), ef.vb);
    chk("small_hcount", 32'(if_small.hcount), es.h);
    chk("small_vcount", 32'(if_small.vcount), es.v);
    chk("small_hsync", 32'(if_small.hsync), es.hs);
    chk("small_vsync", 32'(if_small.vsync), es.vs);
    chk("small_hblnk", 32'(if_small.hblnk), es.hb);
    chk("small_vblnk", 32'(if_small.vblnk), es.vb);
`ifdef VGA_FRAME_CNT_EN
    chk("full_frame_cnt", 32'(if_full.frame_cnt), ef.fc);
    chk("small_frame_cnt", 32'(if_small.frame_cnt), es.fc);
`endif
  endtask

  int prev_fh, prev_fv, prev_sh, prev_sv;
  int prev_fhs, prev_fhb, prev_svs;
  int hs_run, last_h0, last_vs_rise;

  task automatic reset_monitors();
    prev_fh = 0;
    prev_fv = 0;
    prev_sh = 0;
    prev_sv = 0;
    prev_fhs = 0;
    prev_fhb = 0;
    prev_svs = 0;
    hs_run = 0;
    last_h0 = 0;
    last_vs_rise = -1;
  endtask

  task automatic monitors();
    int fh, fv, sh, sv;
    fh = int'(if_full.hcount);
    fv = int'(if_full.vcount);
    sh = int'(if_small.hcount);
    sv = int'(if_small.vcount);
    if (prev_fh == 1055 && prev_fv == 10) begin
      chk("line_wrap_h", 32'(fh), 0);
      chk("line_wrap_v", 32'(fv), 11);
    end
    if (prev_sh == 31 && prev_sv == 17) begin
      chk("frame_edge_h", 32'(sh), 0);
      chk("frame_edge_v", 32'(sv), 0);
      chk("frame_edge_flags",
          {28'd0, if_small.hsync, if_small.vsync,
           if_small.hblnk, if_small.vblnk}, 0);
    end
    if (if_full.hblnk && prev_fhb == 0)
      chk("hblnk_rise_col", 32'(fh), 800);
    if (if_full.hsync) begin
      if (prev_fhs == 0) chk("hsync_rise_col", 32'(fh), 840);
      hs_run++;
    end else if (prev_fhs == 1) begin
      chk("hsync_len", 32'(hs_run), 128);
      hs_run = 0;
    end
    if (fh == 0) begin
      chk("line_period", 32'(n - last_h0), 1056);
      last_h0 = n;
    end
    if (if_small.vsync && prev_svs == 0) begin
      if (last_vs_rise >= 0)
        chk("frame_period", 32'(n - last_vs_rise), 576);
      last_vs_rise = n;
    end
    prev_fh = fh;
    prev_fv = fv;
    prev_sh = sh;
    prev_sv = sv;
    prev_fhs = int'(if_full.hsync);
    prev_fhb = int'(if_full.hblnk);
    prev_svs = int'(if_small.vsync);
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    @(negedge clk);
    check_all();
    monitors();
  endtask

  initial begin
    int len;
    rst = 1'b1;
    #3;
    n = 0;
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();

    rst = 1'b0;
    n = 0;
    reset_monitors();
    len = int'($urandom_range(700, 1500));
    for (int i = 0; i < len; i++) step();

    // Mid-frame asynchronous reset, checked before any clock edge.
    #2;
    rst = 1'b1;
    #1;
    n = 0;
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();

    rst = 1'b0;
    n = 0;
    reset_monitors();
    step();
    chk("first_edge_hcount", 32'(if_full.hcount), 1);

    len = 11700 + int'($urandom_range(0, 600));
    for (int i = 1; i < len; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Free-running VGA raster timing generator for 800x600 @ 60 Hz with a 40 MHz pixel clock. Produces horizontal/vertical pixel counters, sync pulses and blanking flags, all registered and mutually aligned. It is the first stage of the video pipeline. Its outputs feed the drawing stages and the `delay` lines that re-align sync/blank with pipelined pixel data.

## Interface
- `CNT_W`, 11: bit width of `hcount`/`vcount`.
- `H_VISIBLE`, 800: active pixels per line.
- `H_FP`, 40: horizontal front porch, in pixels.
- `H_SYNC`, 128: horizontal sync width, in pixels.
- `H_BP`, 88: horizontal back porch, in pixels.
- `V_VISIBLE`, 600: active lines per frame.
- `V_FP`, 1: vertical front porch, in lines.
- `V_SYNC`, 4: vertical sync width, in lines.
- `V_BP`, 23: vertical back porch, in lines.
- `clk`  in  1  posedge pixel clock (40 MHz).
- `rst`  in  1  reset; asynchronous, active-high.
- `hcount`  out  CNT_W  current pixel column, 0..H_TOTAL-1.
- `vcount`  out  CNT_W  current line, 0..V_TOTAL-1.
- `hsync`  out  1  horizontal sync, active-high.
- `vsync`  out  1  vertical sync, active-high.
- `hblnk`  out  1  high outside the visible columns.
- `vblnk`  out  1  high outside the visible lines.
- `frame_cnt`  out  16  completed-frame counter; present only with `VGA_FRAME_CNT_EN`.

## Operation
- Derived totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (1056); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (628).
- `hcount` increments on every clock. At H_TOTAL-1 it wraps to 0.
- `vcount` increments only on a cycle where `hcount` wraps. When `vcount` is at V_TOTAL-1 and `hcount` wraps, both counters go to 0 on the same edge.
- `hblnk` = (hcount >= H_VISIBLE), i.e. columns 800..1055.
- `hsync` = (hcount in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1]), i.e. columns 840..967.
- `vblnk` = (vcount >= V_VISIBLE), i.e. lines 600..627.
- `vsync` = (vcount in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1]), i.e. lines 601..604.
- Flags are registered. Each flag is computed from the *next* counter values, so on every cycle the flags describe exactly the `hcount`/`vcount` being output. There is no skew between any outputs.
- There is no enable and no stall; the block always runs.

## Timing
- Reset values of all outputs: `hcount`=0, `vcount`=0, `hsync`=0, `vsync`=0, `hblnk`=0, `vblnk`=0, `frame_cnt`=0.
- Reset asserted mid-frame: all outputs go to their reset values immediately, without waiting for a clock edge.
- Reset release: the first rising edge after `rst` falls gives `hcount`=1. The raster then restarts at the top-left corner of the frame.
- Cycle counts:
  - Line period is 1056 cycles.
  - Frame period is 663168 cycles.
  - `hsync` is high for 128 consecutive cycles per line.
  - `vsync` is high for 4 lines, i.e. 4224 consecutive cycles.
- Frame boundary: the edge where (1055,627) becomes (0,0) deasserts `hblnk` and `vblnk` on that same edge.
- Arithmetic: counter compares are unsigned at CNT_W bits. H_TOTAL-1 and V_TOTAL-1 must fit in CNT_W; this is checked by an elaboration-time assertion.

## Configuration
- `VGA_FRAME_CNT_EN` defined:
  - Adds the `frame_cnt` output, a 16-bit counter that increments on the (1055,627) to (0,0) edge.
  - It wraps from 65535 to 0.
  - Its reset value is 0.
- `VGA_FRAME_CNT_EN` undefined: the port and its register are absent, and the remaining behaviour is identical.

## Structure
- `vga_pkg` holds:
  - the default timing constants (H/V visible, porch and sync values);
  - the derived H_TOTAL and V_TOTAL;
  - the counter width.
- The module parameters default to the `vga_pkg` values.
- One sub-module, `wrap_counter`:
  - Parameters: width and modulus.
  - Ports: increment enable, wrap pulse out, asynchronous reset.
  - It is instantiated twice: once for horizontal and once for vertical. The horizontal wrap pulse drives the vertical enable.
- Flag decoding and the registers stay in `vga_timing`.

## Test plan
- Reset: assert `rst` mid-line at (523,312) → all outputs read 0 without any clock edge; release → `hcount` reads 1 after the first edge.
- Line wrap: run until `hcount`=1055, `vcount`=10 → next edge gives `hcount`=0, `vcount`=11.
- Horizontal sync and blank: over one line, `hblnk` rises at `hcount`=800, and `hsync` is high exactly for 840..967 (128 cycles).
- Vertical sync and blank: over one frame, `vblnk` is high for lines 600..627 and `vsync` for lines 601..604; from (1055,627) the next edge gives (0,0) with all flags low.
- Frame period: count cycles between successive `vsync` rising edges → exactly 663168.
- Frame counter: with `VGA_FRAME_CNT_EN`, run 3 frames → `frame_cnt`=3; force the counter near 65535 → it wraps to 0. Without the macro, the build elaborates with no `frame_cnt` port.
